alu_arbiter: RTL and testbench

// Shares one combinational ALU instance between two requesters, e.g. the EX stage
// and a multi-cycle helper unit, using a fair round-robin grant.

---
 rtl/alu_arbiter_if.sv | 24 ++
 rtl/alu_arbiter.sv | 94 +++++++++
 tb/tb_alu_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: two request channels and two response
// channels that share one result/state payload.
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [11:0] req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_num;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [5:0]  rsp_state;

    modport master (
        output req_valid, req_op, req_a, req_b, req_num, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_state
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_num, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_state
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters: latch the
// winner's operands, hold them ALU_CYCLES cycles, register and return the result.
module alu_arbiter #(
    parameter int ALU_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output logic         busy,
    output logic [5:0]   alu_op,
    output logic [31:0]  alu_a,
    output logic [31:0]  alu_b,
    output logic [4:0]   alu_num,
    input  logic [31:0]  alu_result,
    input  logic [5:0]   alu_state
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic       capture;
    logic       release_rsp;

    // With both valid the loser of the previous round wins; last_grant doubles as owner.
    assign grant = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
    assign busy  = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 2'b00;
        accept        = 1'b0;
        capture       = 1'b0;
        release_rsp   = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (bus.req_valid != 2'b00)) begin
                    bus.req_ready = grant ? 2'b10 : 2'b01;
                    accept        = 1'b1;
                    state_nxt     = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[last_grant]) begin
                    release_rsp = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            last_grant     <= 1'b1;
            alu_op         <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_num        <= '0;
            bus.rsp_valid  <= 2'b00;
            bus.rsp_result <= '0;
            bus.rsp_state  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_op     <= grant ? bus.req_op[11:6]   : bus.req_op[5:0];
                alu_a      <= grant ? bus.req_a[63:32]   : bus.req_a[31:0];
                alu_b      <= grant ? bus.req_b[63:32]   : bus.req_b[31:0];
                alu_num    <= grant ? bus.req_num[9:5]   : bus.req_num[4:0];
                last_grant <= grant;
                cnt        <= 4'(ALU_CYCLES - 1);
            end
            if (state == EXEC && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (capture) begin
                bus.rsp_result <= alu_result;
                bus.rsp_state  <= alu_state;
                bus.rsp_valid  <= last_grant ? 2'b10 : 2'b01;
            end
            if (release_rsp)
                bus.rsp_valid <= 2'b00;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed reset/fairness/backpressure steps plus random
// transactions against a transaction-level model, and an ALU_CYCLES=3 timing check.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    alu_arbiter_if ia1();
    alu_arbiter_if ia3();

    logic        busy1, busy3;
    logic [5:0]  alu_op1, alu_op3, alu_st1, alu_st3;
    logic [31:0] alu_a1, alu_b1, alu_a3, alu_b3, alu_r1, alu_r3;
    logic [4:0]  alu_num1, alu_num3;

    // Toy ALU: the state word carries a zero flag and is constant otherwise.
    function automatic logic [31:0] alu_res(logic [5:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] n);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b000000: return b << n;
            default:   return a ^ b;
        endcase
    endfunction

    function automatic logic [5:0] alu_st(logic [31:0] r);
        return {(r == 32'd0), 2'b11, 2'b00, (r != 32'd0)};
    endfunction

    assign alu_r1  = alu_res(alu_op1, alu_a1, alu_b1, alu_num1);
    assign alu_st1 = alu_st(alu_r1);
    assign alu_r3  = alu_res(alu_op3, alu_a3, alu_b3, alu_num3);
    assign alu_st3 = alu_st(alu_r3);

    alu_arbiter #(.ALU_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(ia1), .busy(busy1),
        .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_num(alu_num1),
        .alu_result(alu_r1), .alu_state(alu_st1)
    );

    alu_arbiter #(.ALU_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(ia3), .busy(busy3),
        .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_num(alu_num3),
        .alu_result(alu_r3), .alu_state(alu_st3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, "_busy"}, 64'(busy1), 64'd0);
        chk({tag, "_req_ready"}, 64'(ia1.req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(ia1.rsp_valid), 64'd0);
        chk({tag, "_rsp_result"}, 64'(ia1.rsp_result), 64'd0);
        chk({tag, "_rsp_state"}, 64'(ia1.rsp_state), 64'd0);
        chk({tag, "_alu_op"}, 64'(alu_op1), 64'd0);
        chk({tag, "_alu_a"}, 64'(alu_a1), 64'd0);
        chk({tag, "_alu_b"}, 64'(alu_b1), 64'd0);
        chk({tag, "_alu_num"}, 64'(alu_num1), 64'd0);
    endtask

    // Model state: requester served most recently (1 after reset so req0 leads).
    logic ref_last;

    // One complete transaction on dut1: arbitration, hold, result, optional backpressure.
    task automatic txn(input logic [1:0] v,
                       input logic [5:0] o0, input logic [5:0] o1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] b0, input logic [31:0] b1,
                       input logic [4:0] n0, input logic [4:0] n1,
                       input int hold);
        logic w;
        logic [1:0] oh;
        logic [5:0] eo, es;
        logic [31:0] ea, eb, er;
        logic [4:0] en;
        int k;
        ia1.req_valid = v;
        ia1.req_op    = {o1, o0};
        ia1.req_a     = {a1, a0};
        ia1.req_b     = {b1, b0};
        ia1.req_num   = {n1, n0};
        ia1.rsp_ready = 2'b00;
        #1;
        k = 0;
        while (ia1.req_ready == 2'b00 && k < 20) begin
            tick;
            k++;
        end
        w  = (v == 2'b11) ? ~ref_last : v[1];
        oh = w ? 2'b10 : 2'b01;
        chk("grant", 64'(ia1.req_ready), 64'(oh));
        eo = w ? o1 : o0;
        ea = w ? a1 : a0;
        eb = w ? b1 : b0;
        en = w ? n1 : n0;
        er = alu_res(eo, ea, eb, en);
        es = alu_st(er);
        tick;
        ref_last = w;
        chk("exec_alu_op", 64'(alu_op1), 64'(eo));
        chk("exec_alu_a", 64'(alu_a1), 64'(ea));
        chk("exec_alu_b", 64'(alu_b1), 64'(eb));
        chk("exec_alu_num", 64'(alu_num1), 64'(en));
        chk("exec_busy", 64'(busy1), 64'd1);
        chk("exec_req_ready", 64'(ia1.req_ready), 64'd0);
        chk("exec_rsp_valid", 64'(ia1.rsp_valid), 64'd0);
        tick;
        chk("rsp_valid", 64'(ia1.rsp_valid), 64'(oh));
        chk("rsp_result", 64'(ia1.rsp_result), 64'(er));
        chk("rsp_state", 64'(ia1.rsp_state), 64'(es));
        ia1.rsp_ready = ~oh;
        for (int h = 0; h < hold; h++) begin
            tick;
            chk("hold_rsp_valid", 64'(ia1.rsp_valid), 64'(oh));
            chk("hold_rsp_result", 64'(ia1.rsp_result), 64'(er));
            chk("hold_rsp_state", 64'(ia1.rsp_state), 64'(es));
            chk("hold_req_ready", 64'(ia1.req_ready), 64'd0);
            chk("hold_busy", 64'(busy1), 64'd1);
            chk("hold_alu_a", 64'(alu_a1), 64'(ea));
        end
        ia1.rsp_ready = oh;
        tick;
        ia1.rsp_ready = 2'b00;
        chk("done_rsp_valid", 64'(ia1.rsp_valid), 64'd0);
        chk("done_busy", 64'(busy1), 64'd0);
        chk("idle_alu_op_held", 64'(alu_op1), 64'(eo));
        chk("idle_alu_b_held", 64'(alu_b1), 64'(eb));
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] hold_op;
        logic [31:0] hold_a;
        ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000, 6'b111111};
        rst = 1'b1;
        ia1.req_valid = 2'b00; ia1.req_op = '0; ia1.req_a = '0; ia1.req_b = '0;
        ia1.req_num = '0; ia1.rsp_ready = 2'b00;
        ia3.req_valid = 2'b00; ia3.req_op = '0; ia3.req_a = '0; ia3.req_b = '0;
        ia3.req_num = '0; ia3.rsp_ready = 2'b00;
        tick;
        tick;
        chk_zero1("por");
        rst = 1'b0;
        ref_last = 1'b1;

        // Reset in the middle of EXEC discards the op immediately.
        ia1.req_valid = 2'b01;
        ia1.req_op = {6'b0, 6'b100101};
        ia1.req_a = {32'd0, 32'h1234};
        ia1.req_b = {32'd0, 32'h0f0f};
        ia1.req_num = {5'd0, 5'd9};
        tick;
        chk("pre_rst_busy", 64'(busy1), 64'd1);
        rst = 1'b1;
        #1;
        chk_zero1("mid_exec_rst");
        tick;
        rst = 1'b0;
        ref_last = 1'b1;
        ia1.req_valid = 2'b00;
        tick;
        chk_zero1("after_rst");

        // Both valid after reset -> req0 first; 5+7 add.
        txn(2'b11, 6'b100000, 6'b100101, 32'd5, 32'd1, 32'd7, 32'd2, 5'd0, 5'd0, 0);
        // Equality via subtract on req1.
        txn(2'b10, 6'b0, 6'b100010, 32'd0, 32'd3, 32'd0, 32'd3, 5'd0, 5'd0, 1);
        // Fairness: continuous dual request alternates 0,1,0,1.
        for (int i = 0; i < 4; i++)
            txn(2'b11, 6'b100000, 6'b100100, 32'(i), 32'(i + 100), 32'd10, 32'hff, 5'd0, 5'd0, 0);
        // Lone req1 after serving req1 wins again.
        txn(2'b10, 6'b0, 6'b000000, 32'd0, 32'd0, 32'd0, 32'h3, 5'd0, 5'd4, 0);
        // Backpressure on req0 with req1 pending, then req1 served.
        txn(2'b11, 6'b100101, 6'b100000, 32'h10, 32'h20, 32'h01, 32'h02, 5'd0, 5'd0, 5);
        txn(2'b10, 6'b0, 6'b100000, 32'h0, 32'h20, 32'h0, 32'h02, 5'd0, 5'd0, 0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            txn(v, ops[$urandom_range(0, 5)], ops[$urandom_range(0, 5)],
                $urandom, $urandom, $urandom, $urandom,
                5'($urandom), 5'($urandom), $urandom_range(0, 3));
        end
        ia1.req_valid = 2'b00;

        // ALU_CYCLES=3 timing: hold through edge 3, result after edge 3, re-issue at edge 5.
        ia3.req_valid = 2'b01;
        ia3.req_op = {6'b0, 6'b100010};
        ia3.req_a = {32'd0, 32'd50};
        ia3.req_b = {32'd0, 32'd8};
        ia3.req_num = {5'd0, 5'd3};
        ia3.rsp_ready = 2'b01;
        #1;
        chk("c3_grant", 64'(ia3.req_ready), 64'd1);
        tick;
        hold_op = alu_op3;
        hold_a  = alu_a3;
        chk("c3_alu_op", 64'(alu_op3), 64'(6'b100010));
        chk("c3_alu_a", 64'(alu_a3), 64'd50);
        for (int e = 1; e <= 3; e++) begin
            chk("c3_rsp_valid_low", 64'(ia3.rsp_valid), 64'd0);
            tick;
            chk("c3_alu_op_stable", 64'(alu_op3), 64'(hold_op));
            chk("c3_alu_a_stable", 64'(alu_a3), 64'(hold_a));
            chk("c3_req_ready_low", 64'(ia3.req_ready), 64'd0);
        end
        chk("c3_rsp_valid", 64'(ia3.rsp_valid), 64'd1);
        chk("c3_rsp_result", 64'(ia3.rsp_result), 64'd42);
        chk("c3_rsp_state", 64'(ia3.rsp_state), 64'(6'b011001));
        tick;
        chk("c3_idle_busy", 64'(busy3), 64'd0);
        chk("c3_regrant", 64'(ia3.req_ready), 64'd1);
        ia3.req_valid = 2'b00;
        tick;
        chk("c3_no_grant_when_idle", 64'(ia3.req_ready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
